// File: rtl/writeback_queue.sv
// In-order write-back staging FIFO in front of the register file write port, with two bypass lookups.
// Optional WBQ_COALESCE_EN: a request for the same register as the youngest entry overwrites that entry in place.
module writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ID_W-1:0]            in_reg_id,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       hold,
    output logic                       write,
    output logic [ID_W-1:0]            WriteRegID,
    output logic [DATA_W-1:0]          WriteData,
    input  logic [ID_W-1:0]            ReadRegID1,
    input  logic [ID_W-1:0]            ReadRegID2,
    output logic                       byp_hit1,
    output logic [DATA_W-1:0]          byp_data1,
    output logic                       byp_hit2,
    output logic [DATA_W-1:0]          byp_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]   memId   [DEPTH];
    logic [DATA_W-1:0] memData [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  countReg;

    logic notEmpty;
    logic notFull;
    logic drainNow;
    logic acceptNow;
    logic coalesceHit;
    logic allocate;

    assign count    = countReg;
    assign notEmpty = (countReg != '0);
    assign notFull  = (countReg < CNT_W'(DEPTH));
    assign drainNow = notEmpty && !hold;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready never looks at in_valid, and the producer holds its request until taken.
`ifdef WBQ_COALESCE_EN
    logic [PTR_W-1:0] youngPtr;
    logic             youngMatch;

    assign youngPtr    = tailPtr - PTR_W'(1);
    assign youngMatch  = notEmpty && (in_reg_id == memId[youngPtr]);
    // A lone entry being popped this cycle cannot be patched; the request allocates instead.
    assign coalesceHit = youngMatch && !(drainNow && (countReg == CNT_W'(1)));
    assign in_ready    = notFull || youngMatch;
`else
    assign coalesceHit = 1'b0;
    assign in_ready    = notFull;
`endif

    assign acceptNow = in_valid && in_ready;
    // ID 0 is the hardwired zero register: accepted, never stored.
    assign allocate  = acceptNow && (in_reg_id != '0) && !coalesceHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            countReg   <= '0;
            write      <= 1'b0;
            WriteRegID <= '0;
            WriteData  <= '0;
        end else begin
            if (drainNow) begin
                write      <= 1'b1;
                WriteRegID <= memId[headPtr];
                WriteData  <= memData[headPtr];
                headPtr    <= headPtr + PTR_W'(1);
            end else begin
                write <= 1'b0;
            end
            if (allocate) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            countReg <= countReg + CNT_W'(allocate) - CNT_W'(drainNow);
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (allocate) begin
            memId[tailPtr]   <= in_reg_id;
            memData[tailPtr] <= in_data;
        end
`ifdef WBQ_COALESCE_EN
        else if (acceptNow && coalesceHit) begin
            memData[youngPtr] <= in_data;
        end
`endif
    end

    logic [PTR_W-1:0] slot;

    // Scan oldest to youngest so later matches override earlier ones; output stage is oldest of all.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        slot      = '0;
        if (write && (WriteRegID == ReadRegID1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = WriteData;
        end
        if (write && (WriteRegID == ReadRegID2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = WriteData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = headPtr + PTR_W'(i);
            if (CNT_W'(i) < countReg) begin
                if (memId[slot] == ReadRegID1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = memData[slot];
                end
                if (memId[slot] == ReadRegID2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = memData[slot];
                end
            end
        end
        if (ReadRegID1 == '0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (ReadRegID2 == '0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus a randomized run against a queue-based model.
// Build with +define+WBQ_COALESCE_EN to check the coalescing variant.
module tb_writeback_queue;

    localparam int DATA_W = 32;
    localparam int ID_W   = 6;
    localparam int DEPTH  = 4;
    localparam int ENT_W  = ID_W + DATA_W;
`ifdef WBQ_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ID_W-1:0]   in_reg_id;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              write;
    logic [ID_W-1:0]   WriteRegID;
    logic [DATA_W-1:0] WriteData;
    logic [ID_W-1:0]   ReadRegID1;
    logic [ID_W-1:0]   ReadRegID2;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_id(in_reg_id), .in_data(in_data),
        .hold(hold),
        .write(write), .WriteRegID(WriteRegID), .WriteData(WriteData),
        .ReadRegID1(ReadRegID1), .ReadRegID2(ReadRegID2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending entries {id,data} oldest first, plus the output stage.
    logic [ENT_W-1:0]  exp_q[$];
    logic              mWrite;
    logic [ID_W-1:0]   mId;
    logic [DATA_W-1:0] mData;

    int nCompared;
    int nMismatched;

    function automatic logic [ID_W-1:0] entId(input logic [ENT_W-1:0] e);
        return e[ENT_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] entData(input logic [ENT_W-1:0] e);
        return e[DATA_W-1:0];
    endfunction

    function automatic logic modelReady();
        if (exp_q.size() < DEPTH) return 1'b1;
        if (COALESCE && exp_q.size() > 0 && entId(exp_q[exp_q.size()-1]) == in_reg_id) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest-first search: the first match found is the answer.
    function automatic void modelBypass(input logic [ID_W-1:0] rid, output logic hit,
                                        output logic [DATA_W-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (rid == '0) return;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (entId(exp_q[i]) == rid) begin
                hit  = 1'b1;
                data = entData(exp_q[i]);
                return;
            end
        end
        if (mWrite && mId == rid) begin
            hit  = 1'b1;
            data = mData;
        end
    endfunction

    function automatic void modelClear();
        exp_q.delete();
        mWrite = 1'b0;
        mId    = '0;
        mData  = '0;
    endfunction

    // Driver tasks
    task automatic setIn(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                         input logic h);
        in_valid  = v;
        in_reg_id = id;
        in_data   = d;
        hold      = h;
    endtask

    // One clock: advance the model with the inputs presented, end on the following negedge.
    task automatic tick();
        int n;
        logic rdy, drain, acc, coal;
        logic [ID_W-1:0] vId;
        logic [DATA_W-1:0] vData;
        n     = exp_q.size();
        rdy   = modelReady();
        drain = (n > 0) && !hold;
        acc   = in_valid && rdy;
        vId   = in_reg_id;
        vData = in_data;
        coal  = COALESCE && acc && (n > 0) && (entId(exp_q[n-1]) == vId) && !(drain && n == 1);
        @(posedge clk);
        if (drain) begin
            mWrite = 1'b1;
            {mId, mData} = exp_q.pop_front();
        end else begin
            mWrite = 1'b0;
        end
        if (acc && vId != '0) begin
            if (coal) exp_q[exp_q.size()-1] = {vId, vData};
            else exp_q.push_back({vId, vData});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIn(1'b0, '0, '0, 1'b0);
        ReadRegID1 = '0;
        ReadRegID2 = '0;
        modelClear();
        @(negedge clk);
        @(negedge clk);
        nCompared++; if (write !== 1'b0) begin nMismatched++; $display("FAIL reset_write: got %0b want 0", write); end
        nCompared++; if (WriteRegID !== '0) begin nMismatched++; $display("FAIL reset_id: got %0h want 0", WriteRegID); end
        nCompared++; if (WriteData !== '0) begin nMismatched++; $display("FAIL reset_data: got %0h want 0", WriteData); end
        nCompared++; if (count !== '0) begin nMismatched++; $display("FAIL reset_count: got %0d want 0", count); end
        nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        setIn(1'b1, 6'd5, 32'h0000_00AA, 1'b0);
        #1;
        nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("FAIL single_ready: got %0b want 1", in_ready); end
        tick();
        setIn(1'b0, '0, '0, 1'b0);
        nCompared++; if (write !== 1'b0 || count !== 1) begin nMismatched++; $display("FAIL single_edge1: got write=%0b count=%0d want 0/1", write, count); end
        tick();
        nCompared++; if (write !== 1'b1 || WriteRegID !== 6'd5 || WriteData !== 32'hAA) begin
            nMismatched++; $display("FAIL single_edge2: got %0b/%0d/%0h want 1/5/aa", write, WriteRegID, WriteData); end
        nCompared++; if (count !== 0) begin nMismatched++; $display("FAIL single_count: got %0d want 0", count); end
        tick();
        nCompared++; if (write !== 1'b0 || WriteRegID !== 6'd5 || WriteData !== 32'hAA) begin
            nMismatched++; $display("FAIL single_edge3: got %0b/%0d/%0h want 0/5/aa", write, WriteRegID, WriteData); end
    endtask

    task automatic test_fill_hold();
        for (int k = 1; k <= DEPTH; k++) begin
            setIn(1'b1, ID_W'(k), DATA_W'(k), 1'b1);
            tick();
        end
        setIn(1'b1, 6'd5, 32'd5, 1'b1);
        #1;
        nCompared++; if (in_ready !== 1'b0 || count !== DEPTH) begin
            nMismatched++; $display("FAIL fill_full: got ready=%0b count=%0d want 0/%0d", in_ready, count, DEPTH); end
        tick();
        nCompared++; if (count !== DEPTH || write !== 1'b0) begin
            nMismatched++; $display("FAIL fill_fifth: got count=%0d write=%0b want %0d/0", count, write, DEPTH); end
        setIn(1'b0, '0, '0, 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            nCompared++; if (write !== 1'b1 || WriteRegID !== ID_W'(k) || WriteData !== DATA_W'(k)) begin
                nMismatched++; $display("FAIL fill_drain%0d: got %0b/%0d/%0h want 1/%0d/%0h", k, write, WriteRegID, WriteData, k, k); end
        end
        tick();
        nCompared++; if (write !== 1'b0 || count !== 0) begin
            nMismatched++; $display("FAIL fill_empty: got write=%0b count=%0d want 0/0", write, count); end
    endtask

    task automatic test_bypass_priority();
        setIn(1'b1, 6'd7, 32'h11, 1'b1);
        tick();
        setIn(1'b1, 6'd7, 32'h22, 1'b1);
        tick();
        setIn(1'b0, '0, '0, 1'b1);
        ReadRegID1 = 6'd7;
        ReadRegID2 = 6'd9;
        #1;
        nCompared++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h22) begin
            nMismatched++; $display("FAIL byp_young: got %0b/%0h want 1/22", byp_hit1, byp_data1); end
        nCompared++; if (byp_hit2 !== 1'b0 || byp_data2 !== '0) begin
            nMismatched++; $display("FAIL byp_miss: got %0b/%0h want 0/0", byp_hit2, byp_data2); end
        hold = 1'b0;
        tick();
        nCompared++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h22) begin
            nMismatched++; $display("FAIL byp_after_drain: got %0b/%0h want 1/22", byp_hit1, byp_data1); end
        tick();
        tick();
        nCompared++; if (byp_hit1 !== 1'b0 || count !== 0) begin
            nMismatched++; $display("FAIL byp_drained: got hit=%0b count=%0d want 0/0", byp_hit1, count); end
    endtask

    task automatic test_id_zero();
        setIn(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b0);
        ReadRegID1 = 6'd0;
        tick();
        setIn(1'b0, '0, '0, 1'b0);
        nCompared++; if (count !== 0 || byp_hit1 !== 1'b0 || byp_data1 !== '0) begin
            nMismatched++; $display("FAIL id0_drop: got count=%0d hit=%0b data=%0h want 0/0/0", count, byp_hit1, byp_data1); end
        tick();
        nCompared++; if (write !== 1'b0) begin nMismatched++; $display("FAIL id0_write: got %0b want 0", write); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            setIn(1'b1, ID_W'(10 + k), DATA_W'(32'hA0 + k), 1'b1);
            tick();
        end
        setIn(1'b0, '0, '0, 1'b0);
        tick();
        nCompared++; if (write !== 1'b1 || count !== 2) begin
            nMismatched++; $display("FAIL mid_pre: got write=%0b count=%0d want 1/2", write, count); end
        hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        modelClear();
        nCompared++; if (write !== 1'b0 || count !== 0 || WriteRegID !== '0) begin
            nMismatched++; $display("FAIL mid_reset: got write=%0b count=%0d id=%0d want 0/0/0", write, count, WriteRegID); end
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            nCompared++; if (write !== 1'b0 || count !== 0) begin
                nMismatched++; $display("FAIL mid_stale%0d: got write=%0b count=%0d want 0/0", k, write, count); end
        end
    endtask

    task automatic test_coalesce();
        int writes;
        logic [DATA_W-1:0] lastData;
        writes   = 0;
        lastData = '0;
        setIn(1'b1, 6'd3, 32'h1, 1'b1);
        tick();
        setIn(1'b1, 6'd3, 32'h2, 1'b1);
        tick();
        setIn(1'b0, '0, '0, 1'b1);
        nCompared++; if (count !== (COALESCE ? 1 : 2)) begin
            nMismatched++; $display("FAIL coal_count: got %0d want %0d", count, COALESCE ? 1 : 2); end
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (write === 1'b1) begin
                writes++;
                lastData = WriteData;
            end
        end
        nCompared++; if (writes != (COALESCE ? 1 : 2) || lastData !== 32'h2) begin
            nMismatched++; $display("FAIL coal_writes: got %0d writes last=%0h want %0d/2", writes, lastData, COALESCE ? 1 : 2); end
    endtask

    task automatic test_random();
        logic eHit1, eHit2;
        logic [DATA_W-1:0] eData1, eData2;
        for (int c = 0; c < 400; c++) begin
            setIn(1'b1 & ($urandom_range(0, 3) != 0), ID_W'($urandom_range(0, 7)), $urandom,
                  (c % 50 < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            ReadRegID1 = ID_W'($urandom_range(0, 7));
            ReadRegID2 = ID_W'($urandom_range(0, 7));
            #1;
            modelBypass(ReadRegID1, eHit1, eData1);
            modelBypass(ReadRegID2, eHit2, eData2);
            nCompared++; if (in_ready !== modelReady()) begin
                nMismatched++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, in_ready, modelReady()); end
            nCompared++; if (count !== exp_q.size()) begin
                nMismatched++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count, exp_q.size()); end
            nCompared++; if (write !== mWrite || WriteRegID !== mId || WriteData !== mData) begin
                nMismatched++; $display("FAIL rnd_port c=%0d: got %0b/%0d/%0h want %0b/%0d/%0h", c, write, WriteRegID, WriteData, mWrite, mId, mData); end
            nCompared++; if (byp_hit1 !== eHit1 || byp_data1 !== eData1) begin
                nMismatched++; $display("FAIL rnd_byp1 c=%0d: got %0b/%0h want %0b/%0h", c, byp_hit1, byp_data1, eHit1, eData1); end
            nCompared++; if (byp_hit2 !== eHit2 || byp_data2 !== eData2) begin
                nMismatched++; $display("FAIL rnd_byp2 c=%0d: got %0b/%0h want %0b/%0h", c, byp_hit2, byp_data2, eHit2, eData2); end
            tick();
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_single_write();
        test_fill_hold();
        test_bypass_priority();
        test_id_zero();
        test_reset_mid();
        test_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back staging buffer sitting directly upstream of the register file write port.
- Accepts result writes (register ID and data) from the execute/load side through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one entry per cycle into the register file port `write` / `WriteRegID` / `WriteData`.
- Provides bypass lookups so readers see values that are queued but not yet written.

Parameters:
- DATA_W, 32: data width; matches register file WriteData.
- ID_W, 6: register ID width; matches WriteRegID and ReadRegID.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a write-back request.
- in_ready  out  1  queue can accept the request this cycle.
- in_reg_id  in  ID_W  destination register ID.
- in_data  in  DATA_W  result data.
- hold  in  1  register file port stalled; no drain this cycle.
- write  out  1  register file write enable (registered).
- WriteRegID  out  ID_W  register file write ID (registered).
- WriteData  out  DATA_W  register file write data (registered).
- ReadRegID1  in  ID_W  bypass lookup ID, port 1.
- ReadRegID2  in  ID_W  bypass lookup ID, port 2.
- byp_hit1  out  1  port 1 has a pending newer value.
- byp_data1  out  DATA_W  port 1 bypass value.
- byp_hit2  out  1  port 2 has a pending newer value.
- byp_data2  out  DATA_W  port 2 bypass value.
- count  out  clog2(DEPTH)+1  number of FIFO entries occupied (output stage excluded).

Behaviour:
- Reset (asynchronous, rst_n low):
  - Head, tail and count go to 0.
  - write=0, WriteRegID=0, WriteData=0.
  - All queued entries are discarded, including during a reset mid-operation; no partial write is issued.
- Accept:
  - in_ready = (count < DEPTH), combinational from state only.
  - A transfer occurs when in_valid && in_ready at a rising edge.
- ID 0: a transfer with in_reg_id==0 is accepted but not stored; count is unchanged and write is never issued for it.
- Drain:
  - Each edge, if count>0 and hold==0: output registers load the head entry, write<=1, head advances, count decrements.
  - Otherwise write<=0, and WriteRegID/WriteData keep their previous values.
- Latency: a request accepted at edge N into an empty queue appears with write=1 after edge N+1. Throughput is 1/cycle.
- Simultaneous accept and drain: count unchanged. With count==DEPTH, in_ready=0 even if a drain occurs the same cycle; there is no fall-through when full.
- hold: freezes draining only; accepts continue until full.
- Pointers wrap modulo DEPTH; order is strictly FIFO.
- Bypass (combinational):
  - Search set = the output stage (when write==1) plus all valid FIFO entries.
  - The youngest match wins. FIFO entries are younger than the output stage; a later tail position beats an earlier one.
  - byp_hitN=0 and byp_dataN=0 when there is no match or ReadRegIDN==0.
  - The incoming in_* request is not part of the search.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined:
  - If count>0 and in_reg_id equals the ID of the youngest FIFO entry (tail-1), the transfer overwrites that entry's data in place; count is unchanged.
  - in_ready becomes (count<DEPTH) || (count>0 && in_reg_id==youngest ID), so a coalescing write is accepted even when full.
  - If a drain pops that same entry in the same cycle, no coalescing occurs; the request allocates normally if not full.
- Undefined: every non-zero-ID transfer allocates an entry.

Test Plan:
- Reset then single write: ID 5, data 0x0000_00AA accepted at edge 1 -> write=1, WriteRegID=5, WriteData=0xAA after edge 2; write=0 after edge 3; count returns to 0.
- Fill under hold: hold=1, push IDs 1..4 with data 1..4 -> in_ready=0 at count=4, and a fifth push is not taken. Release hold -> four consecutive write pulses in order 1,2,3,4.
- Bypass priority: queue ID 7=0x11 then ID 7=0x22 with hold=1 -> byp_hit1=1, byp_data1=0x22 for ReadRegID1=7. ReadRegID2=9 -> byp_hit2=0, byp_data2=0.
- ID 0 drop: push ID 0 data 0xFFFF_FFFF -> count stays 0, write never asserts, bypass for ID 0 reports no hit.
- Reset mid-operation: 3 entries queued with hold=1, assert rst_n=0 between edges -> write=0 and count=0 immediately. After release, no stale writes are issued.
- Coalesce (WBQ_COALESCE_EN): hold=1, push ID 3=0x1 then ID 3=0x2 -> count=1. Release hold -> a single write of ID 3 with data 0x2. Without the macro: count=2 and two writes occur.
